// File: rtl/bus_access_arbiter.sv
// Round-robin multi-port line-transfer engine onto a single APB-style word bus.
// Optional macro BUS_TIMEOUT_EN adds an ACCESS-phase timeout that aborts with grant_err.
module bus_access_arbiter #(
  parameter int unsigned NUM_PORTS  = 3,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_PORTS-1:0]              req,
  input  logic [NUM_PORTS-1:0]              req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_PORTS*LINE_WORDS*32-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]              grant,
  output logic [LINE_WORDS*32-1:0]          grant_rdata,
  output logic                              grant_err,
  output logic [ADDR_WIDTH-1:0]             addr,
  output logic                              select,
  output logic                              enable,
  output logic                              write,
  output logic [31:0]                       wdata,
  input  logic [31:0]                       rdata,
  input  logic                              ready
);

  localparam int unsigned PTR_W  = $clog2(NUM_PORTS);
  localparam int unsigned IDX_W  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int unsigned OFF_W  = $clog2(LINE_WORDS) + 2;
  localparam int unsigned LINE_W = LINE_WORDS * 32;
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(LINE_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE_MASK =
    ~((ADDR_WIDTH'(1) << OFF_W) - ADDR_WIDTH'(1));

  if (NUM_PORTS < 2 || LINE_WORDS == 0 || TIMEOUT == 0) begin : g_cfg_check
    $error("bus_access_arbiter: illegal parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        rr_q, rr_d;
  logic [PTR_W-1:0]        owner_q, owner_d;
  logic                    wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [LINE_W-1:0]       line_q, line_d;
  logic                    err_q, err_d;

  logic [NUM_PORTS-1:0]    grant_q, grant_d;
  logic [LINE_W-1:0]       grant_rdata_q, grant_rdata_d;
  logic                    grant_err_q, grant_err_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    select_q, select_d;
  logic                    enable_q, enable_d;
  logic                    write_q, write_d;
  logic [31:0]             wdata_q, wdata_d;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
`endif

  logic                    found;
  logic [PTR_W-1:0]        win;
  int unsigned             p;
  logic                    active;

  // Round-robin scan starting at rr_q, wrapping at NUM_PORTS
  always_comb begin
    found = 1'b0;
    win   = '0;
    p     = 0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      p = 32'(rr_q) + k;
      if (p >= NUM_PORTS) p = p - NUM_PORTS;
      if (!found && req[p]) begin
        found = 1'b1;
        win   = PTR_W'(p);
      end
    end
  end

  // Next state, datapath and registered-output decode
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    wr_d    = wr_q;
    base_d  = base_q;
    idx_d   = idx_q;
    line_d  = line_q;
    err_d   = err_q;
`ifdef BUS_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (found) begin
          owner_d = win;
          wr_d    = req_write[win];
          base_d  = req_addr[32'(win)*ADDR_WIDTH +: ADDR_WIDTH] & BASE_MASK;
          line_d  = req_write[win] ? req_wdata[32'(win)*LINE_W +: LINE_W] : '0;
          err_d   = 1'b0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
`ifdef BUS_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_ACCESS: begin
        if (ready) begin
          if (!wr_q) line_d[32'(idx_q)*32 +: 32] = rdata;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_SETUP;
          end
        end
`ifdef BUS_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          idx_d   = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
        rr_d    = (32'(owner_q) == NUM_PORTS - 1) ? '0 : owner_q + PTR_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    active        = (state_d == S_SETUP) || (state_d == S_ACCESS);
    select_d      = active;
    enable_d      = (state_d == S_ACCESS);
    write_d       = wr_d && (state_d == S_ACCESS);
    addr_d        = active ? (base_d | (ADDR_WIDTH'(idx_d) << 2)) : '0;
    wdata_d       = (active && wr_d) ? line_d[32'(idx_d)*32 +: 32] : '0;
    grant_d       = (state_d == S_DONE) ? (NUM_PORTS'(1) << owner_d) : '0;
    grant_rdata_d = (state_d == S_DONE && !wr_d) ? line_d : '0;
    grant_err_d   = (state_d == S_DONE) && err_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      rr_q          <= '0;
      owner_q       <= '0;
      wr_q          <= 1'b0;
      base_q        <= '0;
      idx_q         <= '0;
      line_q        <= '0;
      err_q         <= 1'b0;
      grant_q       <= '0;
      grant_rdata_q <= '0;
      grant_err_q   <= 1'b0;
      addr_q        <= '0;
      select_q      <= 1'b0;
      enable_q      <= 1'b0;
      write_q       <= 1'b0;
      wdata_q       <= '0;
`ifdef BUS_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      owner_q       <= owner_d;
      wr_q          <= wr_d;
      base_q        <= base_d;
      idx_q         <= idx_d;
      line_q        <= line_d;
      err_q         <= err_d;
      grant_q       <= grant_d;
      grant_rdata_q <= grant_rdata_d;
      grant_err_q   <= grant_err_d;
      addr_q        <= addr_d;
      select_q      <= select_d;
      enable_q      <= enable_d;
      write_q       <= write_d;
      wdata_q       <= wdata_d;
`ifdef BUS_TIMEOUT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  assign grant       = grant_q;
  assign grant_rdata = grant_rdata_q;
  assign grant_err   = grant_err_q;
  assign addr        = addr_q;
  assign select      = select_q;
  assign enable      = enable_q;
  assign write       = write_q;
  assign wdata       = wdata_q;

endmodule

// File: tb/tb_bus_access_arbiter.sv
// Directed bench for bus_access_arbiter: reads, stalled writes, round-robin order, reset abort,
// and stuck-bus behaviour (timeout abort when BUS_TIMEOUT_EN is defined).
module tb_bus_access_arbiter;

  logic          clk;
  logic          rst_n;
  logic [2:0]    req;
  logic [2:0]    req_write;
  logic [95:0]   req_addr;
  logic [383:0]  req_wdata;
  logic [2:0]    grant;
  logic [127:0]  grant_rdata;
  logic          grant_err;
  logic [31:0]   addr;
  logic          select;
  logic          enable;
  logic          write;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          ready;

  bus_access_arbiter #(
    .NUM_PORTS(3), .LINE_WORDS(4), .ADDR_WIDTH(32), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .grant(grant), .grant_rdata(grant_rdata), .grant_err(grant_err),
    .addr(addr), .select(select), .enable(enable), .write(write), .wdata(wdata),
    .rdata(rdata), .ready(ready)
  );

  // Bus slave model: read data is a fixed function of the beat address
  assign rdata = addr + 32'h0100_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  int          stall_beat = -1;
  int          stall_left = 0;
  logic        stuck      = 1'b0;
  logic [31:0] beat_addr [4];
  logic [31:0] beat_wdata[4];
  int          acc_len   [16];
  int          wr_bad;
  int          wr_cyc;

  int          gcyc;
  logic [2:0]  g;
  logic [127:0] rd;
  logic        err;
  int          nbeats;
  logic [2:0]  order[6];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Watch one transfer until grant or budget; drive ready per the stall settings
  task automatic run_xfer(input int budget);
    int cyc;
    cyc = 0; nbeats = 0; gcyc = 0; g = '0; rd = '0; err = 1'b0; wr_bad = 0; wr_cyc = 0;
    for (int i = 0; i < 16; i++) acc_len[i] = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (select || cyc > 0) cyc++;
      ready = stuck ? 1'b0 : !(enable && nbeats == stall_beat && stall_left > 0);
      if (!ready && !stuck) stall_left--;
      if (write && !enable) wr_bad++;
      if (write && enable) wr_cyc++;
      if (enable) begin
        if (nbeats < 16) acc_len[nbeats]++;
        if (ready && nbeats < 4) begin
          beat_addr[nbeats]  = addr;
          beat_wdata[nbeats] = wdata;
        end
        if (ready) nbeats++;
      end
      if (grant != 3'b000) begin
        gcyc = cyc; g = grant; rd = grant_rdata; err = grant_err;
        ready = 1'b1;
        return;
      end
    end
    ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; req_write = '0; ready = 1'b1;
    req_addr  = {32'h3000_0000, 32'h2000_0040, 32'h1000_0014};
    req_wdata = '0;
    req_wdata[128 +: 128] = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
    repeat (3) tick();
    check("rst_grant",  128'(grant), 128'h0);
    check("rst_select", 128'(select), 128'h0);
    check("rst_enable", 128'(enable), 128'h0);
    check("rst_addr",   128'(addr), 128'h0);
    check("rst_wdata",  128'(wdata), 128'h0);
    check("rst_rdata",  grant_rdata, 128'h0);
    rst_n = 1'b1;
    tick();

    // single read, port 0
    req = 3'b001;
    run_xfer(40);
    req = 3'b000;
    check("t1_grant", 128'(g), 128'h1);
    check("t1_latency", 128'(gcyc), 128'd9);
    check("t1_beat0", 128'(beat_addr[0]), 128'h1000_0010);
    check("t1_beat1", 128'(beat_addr[1]), 128'h1000_0014);
    check("t1_beat2", 128'(beat_addr[2]), 128'h1000_0018);
    check("t1_beat3", 128'(beat_addr[3]), 128'h1000_001C);
    check("t1_rdata", rd, {32'h1100_001C, 32'h1100_0018, 32'h1100_0014, 32'h1100_0010});
    check("t1_err", 128'(err), 128'h0);

    // write on port 1 with a three-cycle stall on the second beat
    req_write = 3'b010; req = 3'b010; stall_beat = 1; stall_left = 3;
    run_xfer(40);
    req = 3'b000; req_write = 3'b000; stall_beat = -1;
    check("t2_grant", 128'(g), 128'h2);
    check("t2_wd0", 128'(beat_wdata[0]), 128'hAAAA_0001);
    check("t2_wd1", 128'(beat_wdata[1]), 128'hBBBB_0002);
    check("t2_wd2", 128'(beat_wdata[2]), 128'hCCCC_0003);
    check("t2_wd3", 128'(beat_wdata[3]), 128'hDDDD_0004);
    check("t2_acc0", 128'(acc_len[0]), 128'd1);
    check("t2_acc1", 128'(acc_len[1]), 128'd4);
    check("t2_write_wo_en", 128'(wr_bad), 128'd0);
    check("t2_write_cycles", 128'(wr_cyc), 128'd7);
    check("t2_err", 128'(err), 128'h0);
    check("t2_rdata", rd, 128'h0);

    // all ports requesting from reset: strict rotation
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    req = 3'b111;
    for (int i = 0; i < 6; i++) begin
      run_xfer(40);
      order[i] = g;
    end
    req = 3'b000;
    check("t3_g0", 128'(order[0]), 128'h1);
    check("t3_g1", 128'(order[1]), 128'h2);
    check("t3_g2", 128'(order[2]), 128'h4);
    check("t3_g3", 128'(order[3]), 128'h1);
    check("t3_g4", 128'(order[4]), 128'h2);
    check("t3_g5", 128'(order[5]), 128'h4);

    // pointer wrap: after port 1, pointer sits at 2; ports 0 and 1 waiting
    req = 3'b010;
    run_xfer(40);
    check("t4_first", 128'(g), 128'h2);
    req = 3'b011;
    run_xfer(40);
    check("t4_wrap", 128'(g), 128'h1);
    req = 3'b010;
    run_xfer(40);
    check("t4_next", 128'(g), 128'h2);
    req = 3'b000;
    tick();

    // reset during the third beat of a read
    req = 3'b001;
    begin : wait_beat3
      for (int i = 0; i < 30; i++) begin
        tick();
        if (enable && addr[3:2] == 2'd2) disable wait_beat3;
      end
    end
    check("t5_reached_beat3", 128'(enable && addr[3:2] == 2'd2), 128'h1);
    rst_n = 1'b0;
    #1;
    check("t5_select", 128'(select), 128'h0);
    check("t5_enable", 128'(enable), 128'h0);
    check("t5_addr",   128'(addr), 128'h0);
    check("t5_grant",  128'(grant), 128'h0);
    tick();
    rst_n = 1'b1;
    run_xfer(40);
    req = 3'b000;
    check("t5_restart_addr", 128'(beat_addr[0]), 128'h1000_0010);
    check("t5_restart_grant", 128'(g), 128'h1);

    // bus never ready
    tick();
    stuck = 1'b1; req = 3'b001;
`ifdef BUS_TIMEOUT_EN
    run_xfer(100);
    check("t6_grant", 128'(g), 128'h1);
    check("t6_err", 128'(err), 128'h1);
    check("t6_access_cycles", 128'(acc_len[0]), 128'd16);
    check("t6_rdata", rd, 128'h0);
`else
    run_xfer(1000);
    check("t6_no_grant", 128'(g), 128'h0);
    check("t6_still_waiting", 128'(enable), 128'h1);
`endif
    stuck = 1'b0; req = 3'b000;
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
